// File: rtl/mnist_pkg.sv
// Shared constants and types for the MNIST inference datapath.
// Holds the default logit/class geometry and the argmax stage state encoding.
package mnist_pkg;

  localparam int MNIST_NUM_CLASSES = 10;
  localparam int MNIST_LOGIT_W     = 16;
  localparam int MNIST_CLASS_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FINISH
  } argmax_state_t;

endpackage

// File: rtl/mnist_argmax_cmp.sv
// Signed compare-and-select of an incoming logit against the running max
// (and runner-up when MNIST_ARGMAX_TOP2_EN is defined); returns update flags only.
module mnist_argmax_cmp #(
  parameter int DATA_W = 16
) (
  input  logic              first,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] cur_max,
  output logic              new_max
`ifdef MNIST_ARGMAX_TOP2_EN
  ,
  input  logic              runner_valid,
  input  logic [DATA_W-1:0] cur_runner,
  output logic              new_runner
`endif
);

  // Strict greater-than keeps the earlier (lower) index on ties.
  always_comb begin
    new_max = first || ($signed(in_data) > $signed(cur_max));
  end

`ifdef MNIST_ARGMAX_TOP2_EN
  // The first non-max beat always seeds the runner-up slot.
  always_comb begin
    new_runner = !new_max &&
                 (!runner_valid || ($signed(in_data) > $signed(cur_runner)));
  end
`endif

endmodule

// File: rtl/mnist_argmax_stream.sv
// Argmax over a serial stream of signed logits with in_last framing check.
// Optional top-2 tracking (runner_class, margin) under MNIST_ARGMAX_TOP2_EN.
module mnist_argmax_stream
  import mnist_pkg::*;
#(
  parameter int DATA_W      = MNIST_LOGIT_W,
  parameter int NUM_CLASSES = MNIST_NUM_CLASSES,
  parameter int CLASS_W     = MNIST_CLASS_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_last,
  output logic [CLASS_W-1:0] predicted_class,
  output logic [DATA_W-1:0]  max_score,
  output logic               busy,
  output logic               done,
  output logic               error
`ifdef MNIST_ARGMAX_TOP2_EN
  ,
  output logic [CLASS_W-1:0] runner_class,
  output logic [DATA_W:0]    margin
`endif
);

  localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(NUM_CLASSES - 1);

  argmax_state_t      state_reg;
  logic [CLASS_W-1:0] count_reg;
  logic               first;
  logic               is_final;
  logic               accept;
  logic               new_max;

  assign first    = (count_reg == '0);
  assign is_final = (count_reg == LAST_IDX);
  assign accept   = in_valid && in_ready && (state_reg == COLLECT);

`ifdef MNIST_ARGMAX_TOP2_EN
  logic [DATA_W-1:0] runner_score_reg;
  logic              runner_valid_reg;
  logic              new_runner;

  // Sign-extend both operands so the full signed span fits without wrap.
  assign margin = {max_score[DATA_W-1], max_score}
                - {runner_score_reg[DATA_W-1], runner_score_reg};

  mnist_argmax_cmp #(
    .DATA_W(DATA_W)
  ) u_cmp (
    .first       (first),
    .in_data     (in_data),
    .cur_max     (max_score),
    .new_max     (new_max),
    .runner_valid(runner_valid_reg),
    .cur_runner  (runner_score_reg),
    .new_runner  (new_runner)
  );
`else
  mnist_argmax_cmp #(
    .DATA_W(DATA_W)
  ) u_cmp (
    .first  (first),
    .in_data(in_data),
    .cur_max(max_score),
    .new_max(new_max)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      predicted_class <= '0;
      max_score       <= '0;
      in_ready        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
`ifdef MNIST_ARGMAX_TOP2_EN
      runner_class     <= '0;
      runner_score_reg <= '0;
      runner_valid_reg <= 1'b0;
`endif
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Previous result stays visible until beat 0 of the new frame lands.
          if (start) begin
            state_reg <= COLLECT;
            count_reg <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
`ifdef MNIST_ARGMAX_TOP2_EN
            runner_valid_reg <= 1'b0;
`endif
          end
        end
        COLLECT: begin
          if (accept) begin
            if (new_max) begin
              max_score       <= in_data;
              predicted_class <= count_reg;
`ifdef MNIST_ARGMAX_TOP2_EN
              if (!first) begin
                runner_score_reg <= max_score;
                runner_class     <= predicted_class;
                runner_valid_reg <= 1'b1;
              end
`endif
            end
`ifdef MNIST_ARGMAX_TOP2_EN
            else if (new_runner) begin
              runner_score_reg <= in_data;
              runner_class     <= count_reg;
              runner_valid_reg <= 1'b1;
            end
`endif
            count_reg <= count_reg + 1'b1;
            // in_last must coincide exactly with the final class index.
            if (in_last != is_final) begin
              error     <= 1'b1;
              state_reg <= IDLE;
              in_ready  <= 1'b0;
              busy      <= 1'b0;
            end else if (is_final) begin
              done      <= 1'b1;
              state_reg <= FINISH;
              in_ready  <= 1'b0;
              busy      <= 1'b0;
            end
          end
        end
        FINISH: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mnist_argmax_stream.md
Name: mnist_argmax_stream

Overview:
- Final stage of the MNIST inference datapath.
- Consumes the output-layer logits as a serial valid/ready stream, one signed logit per beat, in class order 0..NUM_CLASSES-1.
- Returns the index of the largest logit as predicted_class, plus a one-cycle done pulse.
- Drives the predicted_class/done pair exposed by mnist_top.

Parameters:
- DATA_W, 16, width of each signed two's-complement logit.
- NUM_CLASSES, 10, number of logits per inference; legal range 2..16.
- CLASS_W, 4, width of the class index; must satisfy 2^CLASS_W >= NUM_CLASSES.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  begin a new inference; sampled only in IDLE.
- in_valid  in  1  logit beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  DATA_W  signed logit.
- in_last  in  1  marks the final logit of the frame.
- predicted_class  out  CLASS_W  argmax index; held stable until the next start.
- max_score  out  DATA_W  logit value at predicted_class; held.
- busy  out  1  high in COLLECT.
- done  out  1  one-cycle pulse: result valid.
- error  out  1  one-cycle pulse: framing error (in_last mismatch).

Behaviour:
- Reset (rst=0 at an edge) forces:
  - state = IDLE;
  - predicted_class, max_score, beat counter = 0;
  - in_ready, busy, done, error = 0.
  - Reset mid-frame discards the partial result.
- States are IDLE, COLLECT, FINISH.
- IDLE:
  - in_ready = 0.
  - start=1 → COLLECT; beat counter and running max cleared.
  - Previous predicted_class/max_score are held until the first beat of the new frame is accepted.
- COLLECT:
  - in_ready = 1, busy = 1.
  - A beat is accepted when in_valid && in_ready.
  - Beat 0 unconditionally loads max_score and index 0.
  - Beat k>0 replaces the running max only if in_data > max_score (signed, strict). Ties keep the lower index.
  - The counter increments per accepted beat. Cycles with in_valid=0 are stalls: no state change.
  - start is ignored in COLLECT.
- Frame end: the accepted beat with counter == NUM_CLASSES-1 → FINISH.
  - in_last must be 1 on exactly that beat.
  - in_last=1 on an earlier beat, or in_last=0 on the final beat → error pulse, go to IDLE.
  - On error: no done pulse, and predicted_class/max_score hold the partial result (don't care).
- FINISH:
  - Lasts one cycle; done = 1, in_ready = 0 → IDLE.
  - Latency: done is high the cycle after the last beat is accepted.
- start in the FINISH cycle is ignored. A new start is accepted from IDLE on the following cycle.
- Comparison uses the full DATA_W signed width; no saturation or truncation.
  - Most-negative value −2^(DATA_W−1) is legal.
  - An all-equal frame yields class 0.

Optional Feature:
- Macro: MNIST_ARGMAX_TOP2_EN.
- Defined: adds outputs runner_class (CLASS_W) and margin (DATA_W+1, unsigned).
  - margin = max_score − runner-up score; runner_class is the second-largest index.
  - Tie rule is the same: the lower index wins.
  - On a new max, the old max is demoted to runner-up.
  - Both outputs are valid with done and reset to 0.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package mnist_pkg holds:
  - MNIST_NUM_CLASSES = 10, MNIST_LOGIT_W = 16, MNIST_CLASS_W = 4;
  - the state enum argmax_state_t {IDLE, COLLECT, FINISH}.
- One natural sub-module: mnist_argmax_cmp.
  - Combinational signed compare-and-select of the incoming beat vs. the current max (and runner-up when TOP2 is enabled).
  - Returns update flags; the FSM stays in the parent.

Test Plan:
- Basic frame: reset, start, stream logits [3,−1,7,2,0,5,−8,1,6,4] back-to-back with in_last on beat 9 → done one cycle after beat 9, predicted_class = 2, max_score = 7.
- Ties and negatives: logits all −32768 except beats 4 and 8 = −5 → predicted_class = 4. All-equal 100 → predicted_class = 0.
- Stalls: same frame as the basic case with in_valid deasserted for 3 random cycles between beats → identical result, and done appears exactly one cycle after the final accepted beat.
- Framing error: in_last asserted on beat 6 → error pulse the next cycle, no done, state IDLE. A following valid frame with max at index 9 → predicted_class = 9.
- Reset mid-frame: drive rst=0 after beat 5, then release → outputs 0, in_ready = 0. start is ignored while rst=0. Restart → correct result.
- TOP2 (macro on): basic frame → runner_class = 8, margin = 1. Frame with max 100 at beat 0 and 100 at beat 3 → class 0, runner_class 3, margin 0.
